// File: rtl/mem_responder.sv
// mem_responder
//   Memory-side responder for the Mini-SRC memory interface. A Read or Write
//   request is captured in IDLE from MAR_addr/MDR_data. It completes after
//   WAIT_CYCLES wait states plus one DONE cycle, using a 2**ADDR_W-word
//   unified RAM.
//
// Ports
//   clock     in   system clock, rising edge
//   clear     in   synchronous active-low reset
//   Read      in   read request (level, sampled in IDLE)
//   Write     in   write request (level, sampled in IDLE)
//   MAR_addr  in   [ADDR_W-1:0] word address
//   MDR_data  in   [DATA_W-1:0] write data
//   Mdatain   out  [DATA_W-1:0] last read data, held until the next read
//   mem_busy  out  high while a request is in flight (IDLE capture .. DONE)
//   mem_ready out  one-cycle completion pulse
//   mem_err   out  one-cycle pulse on Read and Write together in IDLE
//
// state | meaning
// IDLE  | waiting for a request; the request is captured here
// WAIT  | counting down wait states
// DONE  | perform the RAM access and pulse mem_ready
module mem_responder #(
  parameter int ADDR_W      = 9,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              Read,
  input  logic              Write,
  input  logic [ADDR_W-1:0] MAR_addr,
  input  logic [DATA_W-1:0] MDR_data,
  output logic [DATA_W-1:0] Mdatain,
  output logic              mem_busy,
  output logic              mem_ready,
  output logic              mem_err
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_t            state;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              op_wr;

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  // The RAM has no reset. Gating the write with clear suppresses a write
  // whose DONE edge coincides with reset.
  always_ff @(posedge clock) begin
    if (clear && state == ST_DONE && op_wr)
      mem[addr_q] <= data_q;
  end

  always_ff @(posedge clock) begin
    if (!clear) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      op_wr     <= 1'b0;
      Mdatain   <= '0;
      mem_busy  <= 1'b0;
      mem_ready <= 1'b0;
      mem_err   <= 1'b0;
    end else begin
      mem_ready <= 1'b0;
      mem_err   <= 1'b0;
      case (state)
        ST_IDLE: begin
          mem_busy <= 1'b0;
          if (Read ^ Write) begin
            addr_q   <= MAR_addr;
            data_q   <= MDR_data;
            op_wr    <= Write;
            cnt      <= WAIT_INIT;
            mem_busy <= 1'b1;
            state    <= (WAIT_CYCLES > 0) ? ST_WAIT : ST_DONE;
          end else if (Read && Write) begin
            mem_err <= 1'b1;
          end
        end
        ST_WAIT: begin
          // Treating <=1 as terminal means a corrupted zero count still exits.
          if (cnt <= 4'd1) begin
            cnt   <= '0;
            state <= ST_DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_DONE: begin
          if (!op_wr)
            Mdatain <= mem[addr_q];
          mem_ready <= 1'b1;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
